proc_in_fifo: RTL

- Upstream feeder for input port 0 of the filter processor.
- Accepts signed samples from the acquisition side with a valid strobe and buffers them in a first-word-fall-through FIFO.
- Presents the head sample on the processor's io_in bus and pops it on each processor input request.
- Makes underflow and overflow visible to the host through sticky flags.

---
 rtl/proc_io_pkg.sv | 12 +
 rtl/proc_in_fifo_if.sv | 28 ++
 rtl/proc_fifo_mem.sv | 25 ++
 rtl/proc_in_fifo.sv | 110 +++++++++++
 4 files changed

// File: rtl/proc_io_pkg.sv
// Shared definitions for the filter processor I/O blocks: sample type, port
// indices and the default geometry of the input-side FIFO.
package proc_io_pkg;
  localparam int DATA_W = 23;
  typedef logic signed [DATA_W-1:0] sample_t;

  localparam int PORT_IN0 = 0;

  localparam int IN_FIFO_DEPTH  = 16;
  localparam int IN_FIFO_ADDR_W = 4;
  localparam int IN_FIFO_AFULL  = 12;
endpackage

// File: rtl/proc_in_fifo_if.sv
// Source-side and processor-side signals of the port-0 input FIFO.
interface proc_in_fifo_if
  import proc_io_pkg::*;
#(
  parameter int ADDR_W = IN_FIFO_ADDR_W
);
  sample_t           s_data;
  logic              s_valid;
  logic              proc_req_in;
  logic              clr_flags;
  sample_t           proc_io_in;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              ovf;
  logic              udf;

  modport master (
    output s_data, s_valid, proc_req_in, clr_flags,
    input  proc_io_in, count, empty, full, almost_full, ovf, udf
  );

  modport slave (
    input  s_data, s_valid, proc_req_in, clr_flags,
    output proc_io_in, count, empty, full, almost_full, ovf, udf
  );
endinterface

// File: rtl/proc_fifo_mem.sv
// Sample storage: one synchronous write port, one asynchronous read port.
module proc_fifo_mem
  import proc_io_pkg::*;
#(
  parameter int DEPTH  = IN_FIFO_DEPTH,
  parameter int ADDR_W = IN_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  sample_t           wdata,
  input  logic [ADDR_W-1:0] raddr,
  output sample_t           rdata
);
  sample_t mem_r [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/proc_in_fifo.sv
// First-word-fall-through feeder for processor input port 0, with sticky
// overflow/underflow flags and a hold register shown while empty.
module proc_in_fifo
  import proc_io_pkg::*;
#(
  parameter int DEPTH     = IN_FIFO_DEPTH,
  parameter int ADDR_W    = IN_FIFO_ADDR_W,
  parameter int AFULL_LVL = IN_FIFO_AFULL
) (
  input  logic           clk,
  input  logic           rst,
  proc_in_fifo_if.slave  io
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next_s;
  sample_t           hold_r;
  sample_t           head_s;
  logic              empty_r;
  logic              full_r;
  logic              afull_r;
  logic              ovf_r;
  logic              udf_r;
  logic              pop_s;
  logic              push_s;
  logic              ovf_evt_s;
  logic              udf_evt_s;

  proc_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (io.s_data),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // Qualified push/pop events; a full FIFO still accepts when it pops.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    ovf_evt_s    = 1'b0;
    udf_evt_s    = 1'b0;
    count_next_s = count_r;
    if (io.proc_req_in) begin
      pop_s     = ~empty_r;
      udf_evt_s = empty_r;
    end else begin
      pop_s     = 1'b0;
      udf_evt_s = 1'b0;
    end
    if (io.s_valid) begin
      push_s    = ~full_r | pop_s;
      ovf_evt_s = full_r & ~pop_s;
    end else begin
      push_s    = 1'b0;
      ovf_evt_s = 1'b0;
    end
    if (push_s && !pop_s) begin
      count_next_s = count_r + ONE_C;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - ONE_C;
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy, status and sticky flags (new event beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= ZERO_C;
      hold_r   <= {DATA_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
        hold_r   <= head_s;
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == ZERO_C);
      full_r  <= (count_next_s == DEPTH_C);
      afull_r <= (count_next_s >= AFULL_C);
      ovf_r   <= ovf_evt_s | (ovf_r & ~io.clr_flags);
      udf_r   <= udf_evt_s | (udf_r & ~io.clr_flags);
    end
  end

  assign io.proc_io_in  = empty_r ? hold_r : head_s;
  assign io.count       = count_r;
  assign io.empty       = empty_r;
  assign io.full        = full_r;
  assign io.almost_full = afull_r;
  assign io.ovf         = ovf_r;
  assign io.udf         = udf_r;
endmodule
